// File: rtl/tick_bcd_display.sv
// Counts rising edges of a slow asynchronous clock as a 4-digit BCD value and
// scans that value onto a multiplexed active-low seven-segment display.
module tick_bcd_display #(
    parameter int unsigned REFRESH_COUNT = 100000
) (
    input  logic        clk100MHz,
    input  logic        rst,
    input  logic        clk_in,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    output logic [15:0] bcd,
    output logic        tick,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int unsigned REF_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_COUNT - 1);

    logic             s1, s2, s3;
    logic             rise_c;
    logic [15:0]      bcd_step_c;
    logic [REF_W-1:0] ref_cnt, ref_nxt_c;
    logic [1:0]       sel, sel_nxt_c;

    // One decimal step up or down with carry/borrow rippling across digits.
    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic dir_up);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (dir_up) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Reset to all-ones so a clk_in already high at release is not an edge.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c     = s2 & ~s3;
    assign bcd_step_c = bcd_step(bcd, up);

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            tick <= 1'b0;
            bcd  <= 16'h0000;
        end else begin
            tick <= rise_c;
            if (clr) begin
                bcd <= 16'h0000;
            end else if (rise_c && en) begin
                bcd <= bcd_step_c;
            end
        end
    end

    always_comb begin
        ref_nxt_c = ref_cnt + REF_W'(1);
        sel_nxt_c = sel;
        if (ref_cnt == REF_LAST) begin
            ref_nxt_c = '0;
            sel_nxt_c = sel + 2'd1;
        end
    end

    // an and seg follow the next digit select so both move on the advancing edge.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            ref_cnt <= '0;
            sel     <= 2'd0;
            an      <= 4'b1110;
            seg     <= 7'b1000000;
        end else begin
            ref_cnt <= ref_nxt_c;
            sel     <= sel_nxt_c;
            an      <= ~(4'b0001 << sel_nxt_c);
            seg     <= seg_decode(bcd[{sel_nxt_c, 2'b00} +: 4]);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_tick_bcd_display.sv
// Bench for tick_bcd_display: directed phases plus randomized pulse trains,
// every cycle compared against an integer-count / sample-history reference.
module tb_tick_bcd_display;

    localparam int unsigned R = 4;

    logic        clk100MHz = 1'b0;
    logic        rst, clk_in, en, up, clr;
    logic [15:0] bcd;
    logic        tick;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int total = 0;
    int bad   = 0;

    bit         q[$];
    int         cnt      = 0;
    int         n_since  = 0;
    int         tick_seen = 0;
    int         p10[4]   = '{1, 10, 100, 1000};
    logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

    tick_bcd_display #(.REFRESH_COUNT(R)) dut (
        .clk100MHz(clk100MHz),
        .rst(rst),
        .clk_in(clk_in),
        .en(en),
        .up(up),
        .clr(clr),
        .bcd(bcd),
        .tick(tick),
        .seg(seg),
        .an(an),
        .dp(dp)
    );

    always #5 clk100MHz = ~clk100MHz;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference model, then compare every output.
    task automatic cyc();
        bit         rise;
        int         prev_cnt;
        int         sel;
        logic       tick_e;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        prev_cnt = cnt;
        q.push_back(clk_in);
        @(posedge clk100MHz);
        #1;
        // An edge is seen when the sample two edges back is high and the one before it low.
        rise = (q[q.size()-3] == 1'b1) && (q[q.size()-4] == 1'b0);
        if (rst) begin
            cnt     = 0;
            n_since = 0;
            tick_e  = 1'b0;
            for (int i = 1; i <= 3; i++) q[q.size()-i] = 1'b1;
            an_e    = 4'b1110;
            seg_e   = 7'b1000000;
        end else begin
            tick_e = rise;
            if (clr) cnt = 0;
            else if (rise && en) cnt = up ? (cnt + 1) % 10000 : (cnt + 9999) % 10000;
            n_since++;
            sel   = (n_since / R) % 4;
            an_e  = 4'b1111 ^ (4'b0001 << sel);
            seg_e = seg_tab[(prev_cnt / p10[sel]) % 10];
        end
        while (q.size() > 8) void'(q.pop_front());
        if (tick === 1'b1) tick_seen++;
        chk("tick", 16'(tick), 16'(tick_e));
        chk("bcd", bcd, to_bcd(cnt));
        chk("an", 16'(an), 16'(an_e));
        chk("seg", 16'(seg), 16'(seg_e));
        chk("dp", 16'(dp), 16'h0001);
    endtask

    task automatic pulse(input int hi, input int lo);
        clk_in = 1'b1;
        repeat (hi) cyc();
        clk_in = 1'b0;
        repeat (lo) cyc();
    endtask

    task automatic rpulse();
        pulse($urandom_range(2, 6), $urandom_range(2, 6));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) q.push_back(1'b1);
        rst = 1'b1; clk_in = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;

        // Reset with clk_in high, then release while it stays high.
        repeat (5) cyc();
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_an", 16'(an), 16'h000e);
        chk("rst_seg", 16'(seg), 16'h0040);
        rst = 1'b0;
        tick_seen = 0;
        repeat (20) cyc();
        chk("no_tick_at_release", 16'(tick_seen), 16'd0);
        clk_in = 1'b0;
        repeat (5) cyc();

        // Up count with 10/10 pulses.
        en = 1'b1; up = 1'b1;
        tick_seen = 0;
        repeat (12) pulse(10, 10);
        chk("up12_bcd", bcd, 16'h0012);
        chk("up12_ticks", 16'(tick_seen), 16'd12);
        tick_seen = 0;
        pulse(50, 10);
        chk("long_high_ticks", 16'(tick_seen), 16'd1);
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("clr_bcd", bcd, 16'h0000);

        // Wrap and carry/borrow.
        up = 1'b0; rpulse();
        chk("wrap_down", bcd, 16'h9999);
        up = 1'b1; rpulse();
        chk("wrap_up", bcd, 16'h0000);
        repeat (100) rpulse();
        chk("up100", bcd, 16'h0100);
        up = 1'b0; rpulse();
        chk("borrow", bcd, 16'h0099);

        // Enable off still ticks; clr beats a simultaneous edge.
        en = 1'b0;
        tick_seen = 0;
        repeat (5) rpulse();
        chk("en0_ticks", 16'(tick_seen), 16'd5);
        chk("en0_hold", bcd, 16'h0099);
        en = 1'b1;
        clk_in = 1'b1;
        cyc(); cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_edge_tick", 16'(tick), 16'h0001);
        chk("clr_edge_bcd", bcd, 16'h0000);
        cyc(); cyc();
        clk_in = 1'b0;
        repeat (3) cyc();

        // Reach 1234 with 2/2 pulses, then watch a full scan.
        up = 1'b1;
        repeat (1234) pulse(2, 2);
        chk("reach1234", bcd, 16'h1234);
        repeat (16) cyc();

        // Randomized enable/direction/clear against the model.
        for (int k = 0; k < 80; k++) begin
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1) == 1;
            clr = ($urandom_range(0, 9) == 0);
            rpulse();
        end
        clr = 1'b0;

        // Reset one cycle after clk_in rises at count 5.
        en = 1'b1; up = 1'b1;
        clr = 1'b1; cyc(); clr = 1'b0;
        repeat (5) rpulse();
        chk("count5", bcd, 16'h0005);
        tick_seen = 0;
        clk_in = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (6) cyc();
        clk_in = 1'b0;
        repeat (6) cyc();
        chk("midrst_no_tick", 16'(tick_seen), 16'd0);
        chk("midrst_bcd", bcd, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
